// File: rtl/ser_to_par_pkg.sv
// Shared constants and helpers for the ser_to_par deserializer.
// Optional parity is enabled by defining the macro SER_TO_PAR_PARITY_EN.
package ser_to_par_pkg;

`ifdef SER_TO_PAR_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ser_to_par_out_reg.sv
// One-word output holding register for ser_to_par: loads a finished word, holds it until consumed.
// With SER_TO_PAR_PARITY_EN defined it also carries the parity error flag alongside the word.
module ser_to_par_out_reg #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [N-1:0] load_data,
`ifdef SER_TO_PAR_PARITY_EN
   input  logic         load_err,
   output logic         par_err,
`endif
   input  logic         par_ready,
   output logic [N-1:0] par_data,
   output logic         par_valid
);

   // A load never coincides with an occupied register because the top stalls the final bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         par_valid <= 1'b0;
         par_data  <= '0;
      end else if (load) begin
         par_valid <= 1'b1;
         par_data  <= load_data;
      end else if (par_ready) begin
         par_valid <= 1'b0;
      end
   end

`ifdef SER_TO_PAR_PARITY_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         par_err <= 1'b0;
      end else if (load) begin
         par_err <= load_err;
      end
   end
`endif

endmodule

// File: rtl/ser_to_par.sv
// Serial-to-parallel deserializer: one bit per ser handshake, one N-bit word per par handshake.
// Define SER_TO_PAR_PARITY_EN to append an even-parity bit to every frame and report par_err.
module ser_to_par
   import ser_to_par_pkg::*;
#(
   parameter int N         = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         ser_data,
   input  logic         ser_valid,
   output logic         ser_ready,
   output logic [N-1:0] par_data,
   output logic         par_valid,
   input  logic         par_ready
`ifdef SER_TO_PAR_PARITY_EN
  ,output logic         par_err
`endif
);

   localparam int F  = N + PARITY_BITS;
   localparam int CW = cnt_w(F);
   localparam logic [CW-1:0] LAST_IDX = CW'(F - 1);
   localparam logic [CW-1:0] DATA_LEN = CW'(N);

   logic [CW-1:0] count;
   logic [N-1:0]  shift_reg;
   logic [N-1:0]  shift_next;
   logic [N-1:0]  word;
   logic          take;
   logic          last_bit;
   logic          data_bit;
   logic          load;

   assign last_bit  = (count == LAST_IDX);
   assign data_bit  = (count < DATA_LEN);
   assign ser_ready = rstn && !(last_bit && par_valid);
   assign take      = ser_valid && ser_ready;
   assign load      = take && last_bit;

   // Shifting toward the far end means the first bit finishes where LSB_FIRST wants it.
   always_comb begin
      shift_next = shift_reg;
      if (LSB_FIRST) begin
         shift_next = {ser_data, shift_reg[N-1:1]};
      end else begin
         shift_next = {shift_reg[N-2:0], ser_data};
      end
   end

`ifdef SER_TO_PAR_PARITY_EN
   logic word_err;
   assign word     = shift_reg;
   assign word_err = (^shift_reg) ^ ser_data;
`else
   assign word = shift_next;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count     <= '0;
         shift_reg <= '0;
      end else if (take) begin
         count <= last_bit ? '0 : count + 1'b1;
         if (data_bit) begin
            shift_reg <= shift_next;
         end
      end
   end

   ser_to_par_out_reg #(
      .N (N)
   ) u_out_reg (
      .clk       (clk),
      .rstn      (rstn),
      .load      (load),
      .load_data (word),
`ifdef SER_TO_PAR_PARITY_EN
      .load_err  (word_err),
      .par_err   (par_err),
`endif
      .par_ready (par_ready),
      .par_data  (par_data),
      .par_valid (par_valid)
   );

endmodule

// File: tb/tb_ser_to_par.sv
// Self-checking bench for ser_to_par: directed scenarios plus random traffic against a word-level model.
// Parity scenarios are included when SER_TO_PAR_PARITY_EN is defined.
module tb_ser_to_par;
   import ser_to_par_pkg::*;

   localparam int N         = 8;
   localparam bit LSB_FIRST = 1'b1;
   localparam int F         = N + PARITY_BITS;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         ser_data = 1'b0;
   logic         ser_valid = 1'b0;
   logic         ser_ready;
   logic [N-1:0] par_data;
   logic         par_valid;
   logic         par_ready = 1'b0;
`ifdef SER_TO_PAR_PARITY_EN
   logic         par_err;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: bits collected so far, the value they form, and the output slot.
   int   bits_in = 0;
   int   value   = 0;
   logic m_valid = 1'b0;
   int   m_word  = 0;
`ifdef SER_TO_PAR_PARITY_EN
   int   ones    = 0;
   logic m_err   = 1'b0;
`endif

   always #5 clk = ~clk;

   ser_to_par #(
      .N         (N),
      .LSB_FIRST (LSB_FIRST)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .ser_data  (ser_data),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .par_data  (par_data),
      .par_valid (par_valid),
      .par_ready (par_ready)
`ifdef SER_TO_PAR_PARITY_EN
     ,.par_err   (par_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      bits_in = 0;
      value   = 0;
      m_valid = 1'b0;
      m_word  = 0;
`ifdef SER_TO_PAR_PARITY_EN
      ones    = 0;
      m_err   = 1'b0;
`endif
   endtask

   // Called at a falling edge: check outputs against the model, drive inputs, advance the model.
   task automatic apply_stimulus(input logic sv, input logic sd, input logic pr);
      logic exp_ready;
      #1;
      exp_ready = (bits_in == F - 1 && m_valid) ? 1'b0 : 1'b1;
      check("ser_ready", 32'(ser_ready), 32'(exp_ready));
      check("par_valid", 32'(par_valid), 32'(m_valid));
      check("par_data", 32'(par_data), 32'(m_word));
`ifdef SER_TO_PAR_PARITY_EN
      if (m_valid) check("par_err", 32'(par_err), 32'(m_err));
`endif
      ser_valid = sv;
      ser_data  = sd;
      par_ready = pr;
      if (m_valid && pr) m_valid = 1'b0;
      if (sv && exp_ready) begin
         if (bits_in < N && sd) value |= 1 << (LSB_FIRST ? bits_in : N - 1 - bits_in);
`ifdef SER_TO_PAR_PARITY_EN
         ones += int'(sd);
`endif
         bits_in++;
         if (bits_in == F) begin
            m_word  = value;
            m_valid = 1'b1;
`ifdef SER_TO_PAR_PARITY_EN
            m_err   = (ones % 2) != 0;
            ones    = 0;
`endif
            bits_in = 0;
            value   = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      par_ready = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      check("rst_par_valid", 32'(par_valid), 32'd0);
      check("rst_par_data", 32'(par_data), 32'd0);
      check("rst_ser_ready", 32'(ser_ready), 32'd0);
      rstn = 1'b1;
   endtask

   // Frame bit i: data bits LSB of w first, then the even-parity bit (optionally corrupted).
   task automatic send_frame(input logic [7:0] w, input int nbits, input logic pr, input logic flip);
      logic b;
      for (int i = 0; i < nbits; i++) begin
         b = (i < N) ? w[i] : ((^w) ^ flip);
         apply_stimulus(1'b1, b, pr);
      end
   endtask

   task automatic check_output(input string tag, input logic [7:0] exp_word);
      #1;
      check({tag, "_valid"}, 32'(par_valid), 32'd1);
      check({tag, "_data"}, 32'(par_data), 32'(exp_word));
   endtask

   initial begin
      logic       lb;
      logic [7:0] w52;
      w52 = 8'd52;
      lb  = (F > N) ? (^w52) : w52[N-1];

      @(negedge clk);
      do_reset();

      // Single word with a free downstream: valid for exactly one cycle.
      send_frame(8'd62, F, 1'b1, 1'b0);
      check_output("single62", 8'd62);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      #1;
      check("single62_drop", 32'(par_valid), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1);

      // Back-to-back words with ser_valid held high.
      send_frame(8'd62, F, 1'b1, 1'b0);
      check_output("b2b62", 8'd62);
      send_frame(8'd52, F, 1'b1, 1'b0);
      check_output("b2b52", 8'd52);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1);

      // Backpressure: first word held while the second stalls on its final bit.
      send_frame(8'd62, F, 1'b0, 1'b0);
      send_frame(8'd52, F - 1, 1'b0, 1'b0);
      #1;
      check("bp_stall_ready", 32'(ser_ready), 32'd0);
      check("bp_hold_data", 32'(par_data), 32'd62);
      repeat (2) apply_stimulus(1'b1, lb, 1'b0);
      apply_stimulus(1'b1, lb, 1'b1);
      apply_stimulus(1'b1, lb, 1'b0);
      check_output("bp52", 8'd52);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1);

      // Gaps: ser_valid alternates, idle cycles carry junk data.
      for (int i = 0; i < F; i++) begin
         apply_stimulus(1'b1, (i < N) ? w52[i] ^ (8'd62 >> i) & 1'b1 ^ w52[i] : ^(8'd62), 1'b1);
         apply_stimulus(1'b0, 1'($urandom_range(1)), 1'b1);
      end
      #1;
      check("gap62_data", 32'(par_data), 32'd62);
      apply_stimulus(1'b0, 1'b0, 1'b1);

      // Reset mid-frame discards the partial word.
      send_frame(8'd62, 4, 1'b1, 1'b0);
      do_reset();
      send_frame(8'd52, F, 1'b1, 1'b0);
      check_output("rst52", 8'd52);
      apply_stimulus(1'b0, 1'b0, 1'b1);

`ifdef SER_TO_PAR_PARITY_EN
      send_frame(8'd62, F, 1'b0, 1'b0);
      #1;
      check("par_ok_err", 32'(par_err), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      send_frame(8'd62, F, 1'b0, 1'b1);
      #1;
      check("par_bad_err", 32'(par_err), 32'd1);
      check("par_bad_data", 32'(par_data), 32'd62);
      apply_stimulus(1'b0, 1'b0, 1'b1);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
